mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single word-wide RAM port between the CPU's instruction-fetch requester and data-access requester. Arbitrates concurrent requests, sequences each access against the RAM's wait-state handshake and returns read data with a one-cycle ready pulse. Converts partial-word stores (sb/sh) into a read-modify-write, because the RAM port writes whole words only. Sits between the CPU core and the RAM module.

## Interface
- ARB_MODE, 0: 0 = round-robin on ties; 1 = data port always wins ties.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- i_req  in  1  instruction-fetch request; held with i_addr until i_ready.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  32  fetched word; holds its value until the next instruction completion.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata and d_byteen until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wdata  in  32  store data, already lane-aligned.
- d_byteen  in  4  store lane enables; lane k = bits [8k+7:8k]; ignored for loads.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  full loaded word; valid with d_ready, then held.
- mem_addr  out  32  word address to RAM, {addr[31:2],2'b00}.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe; never asserted together with mem_read.
- mem_writedata  out  32  RAM write data.
- mem_readdata  in  32  RAM read data; valid in any cycle with mem_read=1 and mem_waitrequest=0.
- mem_waitrequest  in  1  RAM stall; a strobe completes in the first cycle it is low.

## Operation
- Registered FSM with states IDLE, RD, WR, RMW_RD, RMW_WR and RESP.
- Arbitration happens only in IDLE. The winning requester's request fields are latched into internal registers.
- Tie between i_req and d_req:
  - ARB_MODE=0: the port not served last wins. The last-served flag resets to "data", so the instruction port wins the first tie.
  - ARB_MODE=1: the data port wins.
- IDLE transitions:
  - Instruction grant, or data load: go to RD.
  - Data store with byteen=1111: go to WR.
  - Data store with byteen=0000: go straight to RESP with no RAM access.
  - Data store with any other byteen: go to RMW_RD.
  - No request: stay in IDLE.
- RD: assert mem_read. On waitrequest low, capture mem_readdata and go to RESP.
- WR: assert mem_write with mem_writedata=wdata. On waitrequest low, go to RESP.
- RMW_RD: assert mem_read. On waitrequest low, latch merged = per lane (byteen[k] ? wdata lane : readdata lane) and go to RMW_WR.
- RMW_WR: assert mem_write with mem_writedata=merged. On waitrequest low, go to RESP.
- RESP:
  - Pulse the granted port's ready for exactly one cycle.
  - Load data: drive the captured word on d_rdata. Fetch: drive it on i_rdata.
  - Update the last-served flag.
  - Return to IDLE.
- The non-granted port sees ready=0 for the whole transaction. Its request stays pending and is served from IDLE afterwards.
- Requester inputs that change after the grant are ignored until the next IDLE.
- mem_addr, mem_read, mem_write and mem_writedata are driven from registers or state decode only. They never depend combinationally on i_*/d_* inputs.
- Reset values: all outputs 0, state IDLE, last-served flag = data.

## Timing
- With zero wait states, measured from the cycle in IDLE where req is sampled (cycle 0):
  - Load/fetch: strobe in cycle 1, ready in cycle 2, back in IDLE in cycle 3.
  - Full-word store: same timing as a load.
  - RMW store: read in cycle 1, write in cycle 2, ready in cycle 3.
  - byteen=0000 store: ready in cycle 1.
- Each cycle with mem_waitrequest=1 adds one cycle. The strobe, mem_addr and mem_writedata stay stable throughout the stall.
- Back-to-back requests: a new grant is decided no earlier than the IDLE cycle following RESP.
- Reset asserted mid-transaction:
  - Strobes drop immediately and the in-flight access is abandoned. No ready pulse is issued for it.
  - If reset lands during RMW_WR, the RAM word is undefined. Software restarts after reset.
  - Requesters must re-present their requests after reset deasserts.

## Test plan
- Single fetch: i_req with i_addr=0x104, RAM word 0x8C010000, no waits -> mem_read in cycle 1 with mem_addr=0x104; i_ready pulse in cycle 2 with i_rdata=0x8C010000.
- Tie, ARB_MODE=0: i_req and d_req (load 0x200) both asserted from reset -> fetch served first, then the load. Repeat the tie -> data port served first this time.
- Byte store: RAM[0x100]=0xAABBCCDD, d_we=1, d_addr=0x101, d_byteen=0010, d_wdata=0x00001100 -> RMW sequence; write of 0xAABB11DD to 0x100; d_ready in cycle 3.
- Wait states: load with mem_waitrequest high for 3 cycles -> mem_read and mem_addr held stable for 4 cycles; d_ready 3 cycles later than the zero-wait case; d_rdata correct.
- Zero-enable store: d_byteen=0000 -> no mem_read/mem_write ever asserted; d_ready in cycle 1.
- Reset during RMW_RD with waitrequest high -> mem_read drops in the reset cycle; no d_ready; after release, the re-presented request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one word-wide RAM port between fetch and data requesters
// Partial-word stores are turned into read-modify-write because the RAM writes whole words only.
module mem_port_arbiter #(
    parameter int ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant_d;
    logic        last_d;
    logic        pick_d;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  byteen_q;
    logic [31:0] merged;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // On a tie the data port wins outright in mode 1; otherwise whoever was not served last.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req) begin
            pick_d = (ARB_MODE != 0) ? 1'b1 : !last_d;
        end
    end

    always_comb begin
        merged = mem_readdata;
        for (int k = 0; k < 4; k++) begin
            if (byteen_q[k]) begin
                merged[8*k +: 8] = wdata_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (!pick_d || !d_we) begin
                        state_nxt = RD;
                    end else if (d_byteen == 4'hF) begin
                        state_nxt = WR;
                    end else if (d_byteen == 4'h0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = RMW_RD;
                    end
                end
            end
            RD:      if (!mem_waitrequest) state_nxt = RESP;
            WR:      if (!mem_waitrequest) state_nxt = RESP;
            RMW_RD:  if (!mem_waitrequest) state_nxt = RMW_WR;
            RMW_WR:  if (!mem_waitrequest) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The merged word overwrites wdata_q so both write states drive the RAM from one register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_d  <= 1'b0;
            last_d   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_d  <= pick_d;
                        addr_q   <= pick_d ? d_addr[31:2] : i_addr[31:2];
                        wdata_q  <= d_wdata;
                        byteen_q <= d_byteen;
                    end
                end
                RD: begin
                    if (!mem_waitrequest) begin
                        if (grant_d) begin
                            d_rdata <= mem_readdata;
                        end else begin
                            i_rdata <= mem_readdata;
                        end
                    end
                end
                RMW_RD: begin
                    if (!mem_waitrequest) begin
                        wdata_q <= merged;
                    end
                end
                RESP: begin
                    last_d <= grant_d;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr      = {addr_q, 2'b00};
    assign mem_read      = (state == RD) || (state == RMW_RD);
    assign mem_write     = (state == WR) || (state == RMW_WR);
    assign mem_writedata = mem_write ? wdata_q : 32'h0;
    assign i_ready       = (state == RESP) && !grant_d;
    assign d_ready       = (state == RESP) && grant_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:255];
    logic [31:0] model_mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    int          cyc = 0;
    int          stall_target = 0;
    bit          rand_wait = 1'b0;
    bit          m_last_d = 1'b1;

    int          rd_starts = 0, wr_starts = 0, rd_cycles = 0;
    int          i_rdy_cnt = 0, d_rdy_cnt = 0;
    int          rd_start_cyc = 0, wr_start_cyc = 0, i_rdy_cyc = 0, d_rdy_cyc = 0;
    int          both_err = 0, stable_err = 0, stall_left = 0;
    logic [31:0] rd_start_addr = '0, wr_start_addr = '0, wr_start_data = '0;
    logic [31:0] i_rdy_data = '0, d_rdy_data = '0, prev_addr = '0, prev_wdata = '0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0, prev_stall = 1'b0;

    mem_port_arbiter #(.ARB_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteen(d_byteen), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    assign mem_readdata = ram[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) ram[bd_idx] <= bd_data;
        else if (mem_write && !mem_waitrequest) ram[mem_addr[9:2]] <= mem_writedata;
    end

    // RAM-side monitor: records strobe/ready events and chooses waitrequest for the coming edge.
    always @(negedge clk) begin
        if (mem_read && mem_write) both_err++;
        if (prev_stall && !reset) begin
            if ((prev_rd && !mem_read) || (prev_wr && !mem_write) || mem_addr !== prev_addr ||
                (prev_wr && mem_writedata !== prev_wdata))
                stable_err++;
        end
        if (mem_read && !prev_rd) begin
            rd_starts++; rd_start_cyc = cyc; rd_start_addr = mem_addr; stall_left = stall_target;
        end
        if (mem_write && !prev_wr) begin
            wr_starts++; wr_start_cyc = cyc; wr_start_addr = mem_addr;
            wr_start_data = mem_writedata; stall_left = stall_target;
        end
        if (mem_read) rd_cycles++;
        if (mem_read || mem_write) begin
            if (stall_left > 0) begin
                mem_waitrequest = 1'b1;
                stall_left--;
            end else begin
                mem_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
        end else begin
            mem_waitrequest = 1'b0;
        end
        if (i_ready) begin i_rdy_cnt++; i_rdy_cyc = cyc; i_rdy_data = i_rdata; end
        if (d_ready) begin d_rdy_cnt++; d_rdy_cyc = cyc; d_rdy_data = d_rdata; end
        prev_rd = mem_read;
        prev_wr = mem_write;
        prev_stall = (mem_read || mem_write) && mem_waitrequest;
        prev_addr = mem_addr;
        prev_wdata = mem_writedata;
    end

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk); #1;
        bd_idx = idx; bd_data = val; bd_we = 1'b1;
        model_mem[idx] = val;
        @(negedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk); #1;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        m_last_d = 1'b1;
    endtask

    task automatic wait_any(input int i0, input int d0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (i_rdy_cnt != i0 || d_rdy_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        checks++;
        if ({i_ready, d_ready, i_rdata, d_rdata, mem_addr, mem_read, mem_write, mem_writedata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual i_rdy=%b d_rdy=%b i_rd=%h d_rd=%h addr=%h rd=%b wr=%b wd=%h required all 0",
                     i_ready, d_ready, i_rdata, d_rdata, mem_addr, mem_read, mem_write, mem_writedata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle actual rd=%b wr=%b required 0 0", mem_read, mem_write);
        end
    endtask

    task automatic test_single_fetch;
        int i0, d0, t0;
        bit ok;
        poke(8'h41, 32'h8C010000);
        @(negedge clk); #1;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; t0 = cyc;
        i_addr = 32'h104; i_req = 1'b1;
        wait_any(i0, d0, ok);
        i_req = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL fetch_timeout actual none required i_ready"); end
        checks++;
        if (rd_start_cyc !== t0 + 1 || rd_start_addr !== 32'h104) begin
            errors++;
            $display("FAIL fetch_read actual cyc=%0d addr=%h required cyc=%0d addr=00000104",
                     rd_start_cyc - t0, rd_start_addr, 1);
        end
        checks++;
        if (i_rdy_cyc !== t0 + 2 || i_rdy_data !== 32'h8C010000) begin
            errors++;
            $display("FAIL fetch_ready actual cyc=%0d data=%h required cyc=2 data=8c010000",
                     i_rdy_cyc - t0, i_rdy_data);
        end
        checks++;
        if (d_rdy_cnt !== d0) begin
            errors++;
            $display("FAIL fetch_no_d_ready actual %0d required %0d", d_rdy_cnt, d0);
        end
        @(negedge clk); #1;
        checks++;
        if (i_ready !== 1'b0 || i_rdata !== 32'h8C010000) begin
            errors++;
            $display("FAIL fetch_hold actual rdy=%b data=%h required 0 8c010000", i_ready, i_rdata);
        end
    endtask

    task automatic test_tie;
        int i0, d0;
        bit ok;
        poke(8'hC0, 32'h11112222);
        poke(8'h80, 32'h33334444);
        poke(8'hC1, 32'h55556666);
        pulse_reset();
        @(negedge clk); #1;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt;
        i_addr = 32'h300; i_req = 1'b1;
        d_addr = 32'h200; d_we = 1'b0; d_byteen = 4'hF; d_wdata = 32'h0; d_req = 1'b1;
        wait_any(i0, d0, ok);
        checks++;
        if (!ok || i_rdy_cnt !== i0 + 1 || d_rdy_cnt !== d0 || i_rdy_data !== 32'h11112222) begin
            errors++;
            $display("FAIL tie1_fetch_first actual i=%0d d=%0d data=%h required i=1 d=0 data=11112222",
                     i_rdy_cnt - i0, d_rdy_cnt - d0, i_rdy_data);
        end
        i_addr = 32'h304;
        i0 = i_rdy_cnt;
        wait_any(i0, d0, ok);
        checks++;
        if (!ok || d_rdy_cnt !== d0 + 1 || i_rdy_cnt !== i0 || d_rdy_data !== 32'h33334444) begin
            errors++;
            $display("FAIL tie2_data_first actual i=%0d d=%0d data=%h required i=0 d=1 data=33334444",
                     i_rdy_cnt - i0, d_rdy_cnt - d0, d_rdy_data);
        end
        d_req = 1'b0;
        d0 = d_rdy_cnt;
        wait_any(i0, d0, ok);
        i_req = 1'b0;
        checks++;
        if (!ok || i_rdy_cnt !== i0 + 1 || i_rdy_data !== 32'h55556666) begin
            errors++;
            $display("FAIL tie2_fetch_after actual i=%0d data=%h required i=1 data=55556666",
                     i_rdy_cnt - i0, i_rdy_data);
        end
    endtask

    task automatic test_byte_store;
        int i0, d0, t0;
        bit ok;
        poke(8'h40, 32'hAABBCCDD);
        @(negedge clk); #1;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; t0 = cyc;
        d_we = 1'b1; d_addr = 32'h101; d_byteen = 4'b0010; d_wdata = 32'h00001100; d_req = 1'b1;
        wait_any(i0, d0, ok);
        d_req = 1'b0;
        checks++;
        if (!ok || rd_start_cyc !== t0 + 1 || rd_start_addr !== 32'h100) begin
            errors++;
            $display("FAIL rmw_read actual cyc=%0d addr=%h required cyc=1 addr=00000100",
                     rd_start_cyc - t0, rd_start_addr);
        end
        checks++;
        if (wr_start_cyc !== t0 + 2 || wr_start_addr !== 32'h100 || wr_start_data !== 32'hAABB11DD) begin
            errors++;
            $display("FAIL rmw_write actual cyc=%0d addr=%h data=%h required cyc=2 addr=00000100 data=aabb11dd",
                     wr_start_cyc - t0, wr_start_addr, wr_start_data);
        end
        checks++;
        if (d_rdy_cyc !== t0 + 3 || ram[8'h40] !== 32'hAABB11DD) begin
            errors++;
            $display("FAIL rmw_ready actual cyc=%0d ram=%h required cyc=3 ram=aabb11dd",
                     d_rdy_cyc - t0, ram[8'h40]);
        end
    endtask

    task automatic test_wait_states;
        int i0, d0, t0, rc0;
        bit ok;
        poke(8'h82, 32'hCAFEF00D);
        @(negedge clk); #1;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; t0 = cyc; rc0 = rd_cycles;
        stall_target = 3;
        d_we = 1'b0; d_addr = 32'h20B; d_byteen = 4'h0; d_req = 1'b1;
        wait_any(i0, d0, ok);
        d_req = 1'b0;
        stall_target = 0;
        checks++;
        if (rd_cycles - rc0 !== 4) begin
            errors++;
            $display("FAIL wait_read_len actual %0d required 4", rd_cycles - rc0);
        end
        checks++;
        if (!ok || d_rdy_cyc !== t0 + 5 || d_rdy_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wait_ready actual cyc=%0d data=%h required cyc=5 data=cafef00d",
                     d_rdy_cyc - t0, d_rdy_data);
        end
        checks++;
        if (stable_err !== 0) begin
            errors++;
            $display("FAIL wait_stable actual %0d required 0", stable_err);
        end
    endtask

    task automatic test_zero_enable;
        int i0, d0, t0, rs0, ws0;
        bit ok;
        poke(8'h84, 32'h0BADF00D);
        @(negedge clk); #1;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; t0 = cyc; rs0 = rd_starts; ws0 = wr_starts;
        d_we = 1'b1; d_addr = 32'h210; d_byteen = 4'h0; d_wdata = 32'hFFFFFFFF; d_req = 1'b1;
        wait_any(i0, d0, ok);
        d_req = 1'b0;
        checks++;
        if (!ok || d_rdy_cyc !== t0 + 1) begin
            errors++;
            $display("FAIL zero_ready actual cyc=%0d required cyc=1", d_rdy_cyc - t0);
        end
        checks++;
        if (rd_starts !== rs0 || wr_starts !== ws0 || ram[8'h84] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL zero_no_access actual rd=%0d wr=%0d ram=%h required 0 0 0badf00d",
                     rd_starts - rs0, wr_starts - ws0, ram[8'h84]);
        end
    endtask

    task automatic test_reset_mid;
        int i0, d0, rs0;
        bit ok;
        poke(8'hA0, 32'h12345678);
        @(negedge clk); #1;
        i0 = i_rdy_cnt; d0 = d_rdy_cnt; rs0 = rd_starts;
        stall_target = 50;
        d_we = 1'b1; d_addr = 32'h282; d_byteen = 4'b0011; d_wdata = 32'h0000BEEF; d_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (rd_starts != rs0) break;
        end
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rmid_in_read actual rd=%b required 1", mem_read);
        end
        reset = 1'b1; d_req = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rmid_strobe_drop actual rd=%b wr=%b required 0 0", mem_read, mem_write);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        stall_target = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (d_rdy_cnt !== d0 || ram[8'hA0] !== 32'h12345678) begin
            errors++;
            $display("FAIL rmid_abandon actual d_ready=%0d ram=%h required 0 12345678",
                     d_rdy_cnt - d0, ram[8'hA0]);
        end
        d_req = 1'b1;
        wait_any(i0, d0, ok);
        d_req = 1'b0;
        checks++;
        if (!ok || ram[8'hA0] !== 32'h1234BEEF) begin
            errors++;
            $display("FAIL rmid_retry actual ok=%b ram=%h required 1 1234beef", ok, ram[8'hA0]);
        end
        m_last_d = 1'b1;
    endtask

    task automatic test_random;
        int i0, d0, mode, n, mism;
        bit ok, got_d, use_i, use_d, dwe;
        bit ord [2];
        logic [31:0] r, ia, da, dwd, expw;
        logic [3:0] dbe;
        pulse_reset();
        for (int w = 0; w < 256; w++) begin
            r = $urandom;
            poke(w[7:0], r);
        end
        rand_wait = 1'b1;
        for (int it = 0; it < 80; it++) begin
            mode = int'($urandom_range(0, 2));
            use_i = (mode != 1); use_d = (mode != 0);
            ia = $urandom & 32'h3FF; da = $urandom & 32'h3FF;
            r = $urandom; dbe = r[3:0]; dwe = r[4];
            dwd = $urandom;
            if (use_i && use_d) begin
                ord[0] = !m_last_d; ord[1] = m_last_d; n = 2;
            end else begin
                ord[0] = use_d; ord[1] = 1'b0; n = 1;
            end
            @(negedge clk); #1;
            i0 = i_rdy_cnt; d0 = d_rdy_cnt;
            i_addr = ia; i_req = use_i;
            d_addr = da; d_we = dwe; d_byteen = dbe; d_wdata = dwd; d_req = use_d;
            for (int s = 0; s < n; s++) begin
                wait_any(i0, d0, ok);
                got_d = (d_rdy_cnt != d0);
                checks++;
                if (!ok || got_d !== ord[s] || (i_rdy_cnt != i0 && d_rdy_cnt != d0)) begin
                    errors++;
                    $display("FAIL rand_order it=%0d s=%0d actual ok=%b d=%b required d=%b",
                             it, s, ok, got_d, ord[s]);
                end
                if (!ord[s]) begin
                    expw = model_mem[ia[9:2]];
                    checks++;
                    if (i_rdy_data !== expw) begin
                        errors++;
                        $display("FAIL rand_fetch it=%0d actual %h required %h", it, i_rdy_data, expw);
                    end
                end else if (!dwe) begin
                    expw = model_mem[da[9:2]];
                    checks++;
                    if (d_rdy_data !== expw) begin
                        errors++;
                        $display("FAIL rand_load it=%0d actual %h required %h", it, d_rdy_data, expw);
                    end
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (dbe[k]) model_mem[da[9:2]][8*k +: 8] = dwd[8*k +: 8];
                end
                if (got_d) d_req = 1'b0; else i_req = 1'b0;
                if (!ok) begin i_req = 1'b0; d_req = 1'b0; end
                m_last_d = ord[s];
                i0 = i_rdy_cnt; d0 = d_rdy_cnt;
            end
        end
        rand_wait = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        mism = 0;
        for (int w = 0; w < 256; w++) if (ram[w] !== model_mem[w]) mism++;
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL rand_ram_image actual %0d mismatching words required 0", mism);
        end
        checks++;
        if (both_err !== 0 || stable_err !== 0) begin
            errors++;
            $display("FAIL protocol actual both=%0d unstable=%0d required 0 0", both_err, stable_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_byteen = '0;
        test_reset();
        test_single_fetch();
        test_tie();
        test_byte_store();
        test_wait_states();
        test_zero_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual time limit reached required finish");
        $fatal(1);
    end

endmodule
